// File: rtl/systolic_ctrl_if.sv
// Control/operand bus of the systolic array sequencer: host handshake, lane decode and PE flags.
// master = host/PE-grid side, slave = systolic_ctrl.
interface systolic_ctrl_if #(
    parameter int N    = 4,
    parameter int KMAX = 64
);
    localparam int IW = $clog2(KMAX);

    logic            start_i;
    logic [IW:0]     k_len_i;
    logic            abort_i;
    logic            busy_o;
    logic            done_o;
    logic            pe_start_o;
    logic [N-1:0]    a_valid_o;
    logic [N*IW-1:0] a_idx_o;
    logic [N-1:0]    b_valid_o;
    logic [N*IW-1:0] b_idx_o;
    logic            capture_o;
    logic [N*N-1:0]  ovf_i;
    logic            ovf_o;
    logic [31:0]     busy_cycles_o;
    logic [2:0]      dbg_state;

    modport master (
        output start_i, k_len_i, abort_i, ovf_i,
        input  busy_o, done_o, pe_start_o, a_valid_o, a_idx_o, b_valid_o, b_idx_o,
               capture_o, ovf_o, busy_cycles_o, dbg_state
    );

    modport slave (
        input  start_i, k_len_i, abort_i, ovf_i,
        output busy_o, done_o, pe_start_o, a_valid_o, a_idx_o, b_valid_o, b_idx_o,
               capture_o, ovf_o, busy_cycles_o, dbg_state
    );
endinterface

// File: rtl/systolic_ctrl.sv
// Sequencer for an N x N output-stationary systolic MAC array: skewed operand feed, drain, capture.
// Optional busy-cycle counter enabled by defining SYSTOLIC_CTRL_BUSY_CNT_EN.
module systolic_ctrl #(
    parameter int N    = 4,
    parameter int KMAX = 64
) (
    input logic          clk_i,
    input logic          reset_i,
    systolic_ctrl_if.slave bus
);
    localparam int IW = $clog2(KMAX);
    localparam int CW = $clog2(KMAX + 2*N + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FEED    = 3'd1,
        S_DRAIN   = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [IW:0]     k_q;
    logic            ovf_q;
    logic [CW-1:0]   k_cw;
    logic [CW-1:0]   feed_last;
    logic [CW-1:0]   drain_last;
    logic            accept;
    logic            capture_fire;
    logic            busy;
    logic            pe_start;
    logic            done;
    logic [N-1:0]    lane_valid;
    logic [N*IW-1:0] lane_idx;
    logic [IW:0]     k_clamped;

    assign k_cw       = CW'(k_q);
    assign feed_last  = k_cw + CW'(N - 2);
    assign drain_last = k_cw + CW'(2*N - 1);
    assign accept     = (state_q == S_IDLE) && bus.start_i;
    // Abort in the capture cycle itself suppresses the strobe and the overflow latch.
    assign capture_fire = (state_q == S_CAPTURE) && !bus.abort_i;
    assign k_clamped  = (bus.k_len_i > (IW+1)'(KMAX)) ? (IW+1)'(KMAX) : bus.k_len_i;

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (bus.start_i) state_d = S_FEED;
            S_FEED: begin
                if (bus.abort_i)                           state_d = S_IDLE;
                else if (k_q == '0 || cnt_q == feed_last)  state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (bus.abort_i)               state_d = S_IDLE;
                else if (cnt_q == drain_last)  state_d = S_CAPTURE;
            end
            S_CAPTURE: state_d = bus.abort_i ? S_IDLE : S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy     = 1'b0;
        pe_start = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_FEED, S_DRAIN, S_CAPTURE: begin
                busy     = 1'b1;
                pe_start = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
            k_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (accept) begin
                cnt_q <= '0;
                k_q   <= k_clamped;
                ovf_q <= 1'b0;
            end else begin
                if (busy)         cnt_q <= cnt_q + 1'b1;
                if (capture_fire) ovf_q <= |bus.ovf_i;
            end
        end
    end

    // Lane r sees operand element cnt - r during its K-cycle window; A rows and B columns share the skew.
    always_comb begin
        lane_valid = '0;
        lane_idx   = '0;
        for (int r = 0; r < N; r++) begin
            if ((state_q == S_FEED || state_q == S_DRAIN) &&
                cnt_q >= CW'(r) && cnt_q < CW'(r) + k_cw) begin
                lane_valid[r]         = 1'b1;
                lane_idx[r*IW +: IW]  = IW'(cnt_q - CW'(r));
            end
        end
    end

`ifdef SYSTOLIC_CTRL_BUSY_CNT_EN
    logic [31:0] busy_cnt_q;
    always_ff @(posedge clk_i) begin
        if (reset_i)                          busy_cnt_q <= '0;
        else if (busy && busy_cnt_q != '1)    busy_cnt_q <= busy_cnt_q + 32'd1;
    end
    assign bus.busy_cycles_o = busy_cnt_q;
`else
    assign bus.busy_cycles_o = '0;
`endif

    assign bus.busy_o     = busy;
    assign bus.done_o     = done;
    assign bus.pe_start_o = pe_start;
    assign bus.capture_o  = capture_fire;
    assign bus.ovf_o      = ovf_q;
    assign bus.a_valid_o  = lane_valid;
    assign bus.a_idx_o    = lane_idx;
    assign bus.b_valid_o  = lane_valid;
    assign bus.b_idx_o    = lane_idx;
    assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed self-checking bench for systolic_ctrl (N=4, KMAX=64) with hand-computed expectations.
module tb_systolic_ctrl;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    systolic_ctrl_if #(.N(4), .KMAX(64)) bus ();

    systolic_ctrl #(.N(4), .KMAX(64)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Call from IDLE; returns positioned in the first FEED cycle (cnt 0).
    task automatic start_run(input int k);
        bus.k_len_i = 7'(k);
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},     32'(bus.busy_o), 0);
        check({tag, "_done"},     32'(bus.done_o), 0);
        check({tag, "_pe_start"}, 32'(bus.pe_start_o), 0);
        check({tag, "_capture"},  32'(bus.capture_o), 0);
        check({tag, "_ovf"},      32'(bus.ovf_o), 0);
        check({tag, "_a_valid"},  32'(bus.a_valid_o), 0);
        check({tag, "_a_idx"},    32'(bus.a_idx_o), 0);
        check({tag, "_b_valid"},  32'(bus.b_valid_o), 0);
        check({tag, "_b_idx"},    32'(bus.b_idx_o), 0);
        check({tag, "_bcycles"},  bus.busy_cycles_o, 0);
        check({tag, "_state"},    32'(bus.dbg_state), 0);
    endtask

    // Runs one product to completion and reports the cycle offsets of capture and done.
    task automatic run_timed(input int k, output int cap_t, output int done_t);
        cap_t  = -1;
        done_t = -1;
        start_run(k);
        for (int t = 0; t < 200; t++) begin
            if (bus.capture_o && cap_t < 0) cap_t = t;
            if (bus.done_o) begin
                done_t = t;
                break;
            end
            tick();
        end
        tick();
    endtask

    logic [3:0] av_exp [0:7];
    int pe_cnt;
    int cap_t;
    int done_t;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        av_exp  = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};
        reset       = 1'b1;
        bus.start_i = 1'b0;
        bus.k_len_i = '0;
        bus.abort_i = 1'b0;
        bus.ovf_i   = '0;
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // K=4: skewed lanes, capture at cnt 12, done at cnt 13, ovf bit 5 latched at capture.
        start_run(4);
        pe_cnt = 0;
        for (int t = 0; t < 14; t++) begin
            bus.ovf_i = (t == 12) ? 16'h0020 : 16'h0000;
            if (bus.pe_start_o) pe_cnt++;
            check("k4_capture", 32'(bus.capture_o), 32'(t == 12));
            check("k4_done",    32'(bus.done_o),    32'(t == 13));
            check("k4_busy",    32'(bus.busy_o),    32'(t <= 12));
            check("k4_a_valid", 32'(bus.a_valid_o), 32'((t < 8) ? av_exp[t] : 4'h0));
            check("k4_b_valid", 32'(bus.b_valid_o), 32'((t < 8) ? av_exp[t] : 4'h0));
            if (t >= 3 && t <= 6)
                check("k4_a_idx3", 32'(bus.a_idx_o[18 +: 6]), 32'(t - 3));
            if (t == 3) begin
                check("k4_a_idx_all", 32'(bus.a_idx_o), 32'({6'd0, 6'd1, 6'd2, 6'd3}));
                check("k4_b_idx_all", 32'(bus.b_idx_o), 32'({6'd0, 6'd1, 6'd2, 6'd3}));
            end
            if (t == 13) check("k4_ovf_set", 32'(bus.ovf_o), 1);
            tick();
        end
        bus.ovf_i = '0;
        check("k4_pe_cycles", 32'(pe_cnt), 13);
        check("k4_idle_busy", 32'(bus.busy_o), 0);
        check("ovf_hold", 32'(bus.ovf_o), 1);

        // K=0: no valid lanes, capture at 8, done at 9, ovf cleared by start.
        start_run(0);
        check("k0_ovf_cleared", 32'(bus.ovf_o), 0);
        for (int t = 0; t < 10; t++) begin
            check("k0_a_valid", 32'(bus.a_valid_o), 0);
            check("k0_capture", 32'(bus.capture_o), 32'(t == 8));
            check("k0_done",    32'(bus.done_o),    32'(t == 9));
            tick();
        end
        check("k0_ovf_clean", 32'(bus.ovf_o), 0);

        // Abort at cnt 5 of K=8, restart two cycles later with K=2.
        start_run(8);
        for (int t = 0; t < 5; t++) tick();
        bus.abort_i = 1'b1;
        tick();
        bus.abort_i = 1'b0;
        check("abort_pe_start", 32'(bus.pe_start_o), 0);
        check("abort_busy",     32'(bus.busy_o), 0);
        check("abort_state",    32'(bus.dbg_state), 0);
        for (int t = 0; t < 2; t++) begin
            check("abort_no_capture", 32'(bus.capture_o), 0);
            check("abort_no_done",    32'(bus.done_o), 0);
            tick();
        end
        run_timed(2, cap_t, done_t);
        check("restart_cap_t",  32'(cap_t), 10);
        check("restart_done_t", 32'(done_t), 11);

        // K above KMAX clamps to 64.
        run_timed(100, cap_t, done_t);
        check("clamp_cap_t",  32'(cap_t), 72);
        check("clamp_done_t", 32'(done_t), 73);

        // start held high: one run while busy, next accepted in the IDLE cycle after done.
        bus.k_len_i = 7'd1;
        bus.start_i = 1'b1;
        tick();
        for (int t = 0; t < 13; t++) begin
            check("hold_busy", 32'(bus.busy_o), 32'(t <= 9 || t == 12));
            check("hold_done", 32'(bus.done_o), 32'(t == 10));
            tick();
        end
        bus.start_i = 1'b0;
        done_t = -1;
        for (int t = 0; t < 30; t++) begin
            if (bus.done_o) begin
                done_t = t;
                break;
            end
            tick();
        end
        check("hold_second_done_seen", 32'(done_t >= 0), 1);
        tick();

        // Reset at cnt 3 clears every output.
        start_run(4);
        for (int t = 0; t < 3; t++) tick();
        reset = 1'b1;
        tick();
        check_all_zero("midreset");
        reset = 1'b0;

        // Four busy cycles then abort: busy-cycle counter shows 4 when enabled.
        start_run(4);
        for (int t = 0; t < 3; t++) tick();
        bus.abort_i = 1'b1;
        tick();
        bus.abort_i = 1'b0;
`ifdef SYSTOLIC_CTRL_BUSY_CNT_EN
        check("busy_cycles", bus.busy_cycles_o, 4);
`else
        check("busy_cycles", bus.busy_cycles_o, 0);
`endif
        check("busy_cycles_abort_idle", 32'(bus.busy_o), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
